// File: rtl/hilo_div_unit.sv
// hilo_div_unit: multi-cycle restoring divider for DIV/DIVU.
// It produces one quotient bit per cycle. The quotient goes to LO and the
// remainder goes to HI. Results leave through a valid/ack handshake.
// A combinational stall request holds the divide in EX until its result is ready.
module hilo_div_unit #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   input  logic              signed_div,
   input  logic [DATA_W-1:0] dividend,
   input  logic [DATA_W-1:0] divisor,
   input  logic              annul,
   input  logic              result_ack,
   output logic              busy,
   output logic              stall_req,
   output logic              result_valid,
   output logic [DATA_W-1:0] result_lo,
   output logic [DATA_W-1:0] result_hi
);

   localparam int CNT_W = $clog2(DATA_W);
   localparam int PR_W  = 2 * DATA_W + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DIVZERO,
      S_ON,
      S_END
   } state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   dividend_q, dividend_d;      // raw dividend, returned as HI on divide-by-zero
   logic [DATA_W-1:0]   divisor_mag_q, divisor_mag_d;
   logic                q_neg_q, q_neg_d;            // negate quotient at the end
   logic                r_neg_q, r_neg_d;            // negate remainder at the end
   logic [PR_W-1:0]     pr_q, pr_d;                  // {partial remainder, quotient bits}
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   lo_q, lo_d;
   logic [DATA_W-1:0]   hi_q, hi_d;

   // One restoring step. Shift left, then trial-subtract the divisor from the upper half.
   logic [PR_W-1:0]     pr_shift;
   logic [DATA_W:0]     trial;
   logic [PR_W-1:0]     pr_step;
   logic [DATA_W-1:0]   dividend_mag;
   logic [DATA_W-1:0]   divisor_mag_in;

   // Datapath for one radix-2 step, plus the operand magnitudes taken at start.
   always_comb begin
      pr_shift       = pr_q << 1;
      trial          = pr_shift[PR_W-1:DATA_W] - {1'b0, divisor_mag_q};
      if (trial[DATA_W]) begin
         pr_step = pr_shift;
      end else begin
         pr_step = {trial, pr_shift[DATA_W-1:1], 1'b1};
      end
      dividend_mag   = (signed_div && dividend[DATA_W-1]) ? -dividend : dividend;
      divisor_mag_in = (signed_div && divisor[DATA_W-1])  ? -divisor  : divisor;
   end

   // Next-state and datapath update. annul wins over start and result_ack.
   always_comb begin
      state_d       = state_q;
      dividend_d    = dividend_q;
      divisor_mag_d = divisor_mag_q;
      q_neg_d       = q_neg_q;
      r_neg_d       = r_neg_q;
      pr_d          = pr_q;
      cnt_d         = cnt_q;
      lo_d          = lo_q;
      hi_d          = hi_q;

      if (annul) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  dividend_d    = dividend;
                  divisor_mag_d = divisor_mag_in;
                  q_neg_d       = signed_div & (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
                  r_neg_d       = signed_div & dividend[DATA_W-1];
                  pr_d          = {{(DATA_W+1){1'b0}}, dividend_mag};
                  cnt_d         = '0;
                  state_d       = (divisor == '0) ? S_DIVZERO : S_ON;
               end
            end
            S_DIVZERO: begin
               lo_d    = '1;
               hi_d    = dividend_q;
               state_d = S_END;
            end
            S_ON: begin
               pr_d  = pr_step;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(DATA_W - 1)) begin
                  // Signs are applied as the last step retires, so END holds final values.
                  lo_d    = q_neg_q ? -pr_step[DATA_W-1:0] : pr_step[DATA_W-1:0];
                  hi_d    = r_neg_q ? -pr_step[2*DATA_W-1:DATA_W] : pr_step[2*DATA_W-1:DATA_W];
                  state_d = S_END;
               end
            end
            S_END: begin
               if (result_ack) begin
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q       <= S_IDLE;
         dividend_q    <= '0;
         divisor_mag_q <= '0;
         q_neg_q       <= 1'b0;
         r_neg_q       <= 1'b0;
         pr_q          <= '0;
         cnt_q         <= '0;
         lo_q          <= '0;
         hi_q          <= '0;
      end else begin
         state_q       <= state_d;
         dividend_q    <= dividend_d;
         divisor_mag_q <= divisor_mag_d;
         q_neg_q       <= q_neg_d;
         r_neg_q       <= r_neg_d;
         pr_q          <= pr_d;
         cnt_q         <= cnt_d;
         lo_q          <= lo_d;
         hi_q          <= hi_d;
      end
   end

   assign busy         = (state_q != S_IDLE);
   assign result_valid = (state_q == S_END);
   assign stall_req    = start & ~result_valid & ~annul;
   assign result_lo    = lo_q;
   assign result_hi    = hi_q;

endmodule

// File: tb/tb_hilo_div_unit.sv
// Testbench for hilo_div_unit. A cycle-level behavioural model is compared
// with the DUT on every cycle. Stimulus is directed cases plus randomized divides.
module tb_hilo_div_unit;

   logic        clk = 1'b0;
   logic        resetn;
   logic        start;
   logic        signed_div;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        annul;
   logic        result_ack;
   logic        busy;
   logic        stall_req;
   logic        result_valid;
   logic [31:0] result_lo;
   logic [31:0] result_hi;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   hilo_div_unit #(.DATA_W(32)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .start        (start),
      .signed_div   (signed_div),
      .dividend     (dividend),
      .divisor      (divisor),
      .annul        (annul),
      .result_ack   (result_ack),
      .busy         (busy),
      .stall_req    (stall_req),
      .result_valid (result_valid),
      .result_lo    (result_lo),
      .result_hi    (result_hi)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference arithmetic. Signed results are computed in 64 bits, so the overflow case wraps.
   function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                   output logic [31:0] q, output logic [31:0] r);
      longint sa, sb, qq, rr;
      if (b == 32'h0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         qq = sa / sb;
         rr = sa % sb;
         q  = qq[31:0];
         r  = rr[31:0];
      end else begin
         q = a / b;
         r = a % b;
      end
   endfunction

   // Behavioural model. A divide accepted at an edge becomes valid after a fixed number
   // of further edges: 1 for a zero divisor, 32 otherwise.
   logic        m_busy, m_valid;
   logic [31:0] m_lo, m_hi, m_pend_lo, m_pend_hi;
   int          m_wait;

   always @(posedge clk) begin
      if (!resetn) begin
         m_busy = 1'b0; m_valid = 1'b0; m_lo = '0; m_hi = '0; m_wait = 0;
      end else if (annul) begin
         m_busy = 1'b0; m_valid = 1'b0;
      end else if (!m_busy) begin
         if (start) begin
            m_busy = 1'b1;
            m_wait = (divisor == 32'h0) ? 1 : 32;
            ref_div(dividend, divisor, signed_div, m_pend_lo, m_pend_hi);
         end
      end else if (m_valid) begin
         if (result_ack) begin
            m_busy = 1'b0; m_valid = 1'b0;
         end
      end else begin
         m_wait--;
         if (m_wait == 0) begin
            m_valid = 1'b1; m_lo = m_pend_lo; m_hi = m_pend_hi;
         end
      end
   end

   // Per-cycle comparison against the model, sampled on the falling edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("busy", {31'b0, busy}, {31'b0, m_busy});
         check("result_valid", {31'b0, result_valid}, {31'b0, m_valid});
         check("stall_req", {31'b0, stall_req}, {31'b0, start & ~m_valid & ~annul});
         check("result_lo", result_lo, m_lo);
         check("result_hi", result_hi, m_hi);
      end
   end

   // Runs one divide. lat is the cycle count from the start cycle to the first valid cycle.
   // annul_at >= 0 cancels the divide in that cycle. Operand inputs are scrambled while it runs.
   task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input int annul_at, input int ack_delay, input bit keep_start,
                         output int lat);
      start = 1'b1; signed_div = s; dividend = a; divisor = b; lat = 0;
      while (1) begin
         if (lat == annul_at) begin
            annul = 1'b1;
            @(posedge clk); #1;
            annul = 1'b0; start = 1'b0; lat = -1;
            return;
         end
         @(negedge clk);
         if (result_valid) break;
         if (lat > 100) begin
            checks++; failures++;
            $display("FAIL timeout: result_valid not seen after %0d cycles, expected within 40", lat);
            start = 1'b0; lat = -1;
            return;
         end
         @(posedge clk); #1;
         lat++;
         dividend = $urandom; divisor = $urandom; signed_div = 1'($urandom);
      end
      #1;
      repeat (ack_delay) begin @(posedge clk); #1; end
      result_ack = 1'b1;
      @(posedge clk); #1;
      result_ack = 1'b0;
      if (!keep_start) start = 1'b0;
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'h1;
         4: return 32'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [31:0] q, r;
      int lat, lat2;
      resetn = 1'b0; start = 1'b0; signed_div = 1'b0; dividend = '0; divisor = '0;
      annul = 1'b0; result_ack = 1'b0;
      @(posedge clk); #1;
      chk_en = 1'b1;
      @(posedge clk); #1;
      resetn = 1'b1;

      // Hand-computed values that pin the reference arithmetic.
      ref_div(32'd7, 32'd2, 1'b0, q, r);
      check("ref_u7_2_lo", q, 32'd3);           check("ref_u7_2_hi", r, 32'd1);
      ref_div(32'hFFFF_FFF9, 32'd2, 1'b1, q, r);
      check("ref_sm7_2_lo", q, 32'hFFFF_FFFD);  check("ref_sm7_2_hi", r, 32'hFFFF_FFFF);
      ref_div(32'hFFFF_FFF9, 32'd2, 1'b0, q, r);
      check("ref_um7_2_lo", q, 32'h7FFF_FFFC);  check("ref_um7_2_hi", r, 32'd1);
      ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, q, r);
      check("ref_ovf_lo", q, 32'h8000_0000);    check("ref_ovf_hi", r, 32'd0);
      ref_div(32'h1234, 32'd0, 1'b1, q, r);
      check("ref_dz_lo", q, 32'hFFFF_FFFF);     check("ref_dz_hi", r, 32'h1234);

      // Directed divides and their latencies.
      do_div(32'd7, 32'd2, 1'b0, -1, 0, 1'b0, lat);               check("lat_u7_2", lat, 33);
      do_div(32'hFFFF_FFF9, 32'd2, 1'b1, -1, 1, 1'b0, lat);       check("lat_sm7_2", lat, 33);
      do_div(32'hFFFF_FFF9, 32'd2, 1'b0, -1, 0, 1'b0, lat);
      do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, -1, 0, 1'b0, lat);
      do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1, 0, 1'b0, lat);
      do_div(32'h1234, 32'd0, 1'b0, -1, 2, 1'b0, lat);            check("lat_divzero", lat, 2);

      // Cancel at T+10, then a fresh 100/7.
      do_div(32'd55, 32'd3, 1'b0, 10, 0, 1'b0, lat);
      @(posedge clk); #1;
      do_div(32'd100, 32'd7, 1'b0, -1, 0, 1'b0, lat);             check("lat_after_annul", lat, 33);

      // Reset in the middle of a divide.
      start = 1'b1; signed_div = 1'b1; dividend = 32'd1000; divisor = 32'd9;
      repeat (5) begin @(posedge clk); #1; end
      resetn = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1; start = 1'b0;
      @(posedge clk); #1;

      // Back-to-back divides: start stays high across the ack.
      do_div(32'd12345, 32'd17, 1'b0, -1, 0, 1'b1, lat);
      do_div(32'hFFFF_0000, 32'd3, 1'b1, -1, 0, 1'b0, lat2);
      check("lat_b2b_first", lat, 33);
      check("lat_b2b_second", lat2, 33);

      // Randomized divides with occasional cancels, ack delays and back-to-back starts.
      for (int i = 0; i < 150; i++) begin
         int an;
         an = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 30)) : -1;
         do_div(pick_operand(), pick_operand(), 1'($urandom), an,
                int'($urandom_range(0, 2)), ($urandom_range(0, 3) == 0), lat);
      end
      start = 1'b0;
      repeat (3) begin @(posedge clk); #1; end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/hilo_div_unit.md
Name: hilo_div_unit

Overview:
- Multi-cycle 32-bit divider serving the EX stage for DIV/DIVU, i.e. the operations for which the main decoder raises write_hilo.
- Accepts a start request with operands and a signedness flag.
- Iterates one quotient bit per cycle and returns quotient (LO) and remainder (HI) through a valid/ack handshake.
- Drives a stall request so the pipeline holds the divide in EX until the HI/LO result can be written.

Parameters:
- DATA_W, 32, operand/result width; iteration count equals DATA_W.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  reset, synchronous, active-low.
- start  in  1  divide request; held high by EX while the DIV/DIVU instruction occupies EX.
- signed_div  in  1  1 = DIV (two's complement), 0 = DIVU.
- dividend  in  DATA_W  rs operand.
- divisor  in  DATA_W  rt operand.
- annul  in  1  flush/exception cancel of the in-flight divide.
- result_ack  in  1  EX advancing; consumes the result.
- busy  out  1  state != IDLE.
- stall_req  out  1  combinational: start & ~result_valid & ~annul.
- result_valid  out  1  result_lo/result_hi valid.
- result_lo  out  DATA_W  quotient.
- result_hi  out  DATA_W  remainder.

Behaviour:
- Reset (resetn=0 at a clock edge): state=IDLE; busy=0, result_valid=0, result_lo=0, result_hi=0; applies mid-operation and discards any work in progress.
- States: IDLE, DIVZERO, ON, END.
- IDLE:
  - If start & ~annul at edge T: latch dividend, divisor and signed_div.
  - divisor==0 -> DIVZERO.
  - Otherwise load magnitudes (abs if signed_div), clear counter, go to ON.
  - Later changes on operand inputs are ignored.
- DIVZERO: one cycle, then END with result_lo=32'hFFFFFFFF, result_hi=latched dividend. result_valid=1 at T+2.
- ON:
  - Restoring radix-2 step per cycle on a (2*DATA_W+1)-bit partial-remainder register.
  - Shift left one; trial-subtract divisor magnitude from the upper half.
  - If non-negative, keep the difference and set the quotient bit to 1; else restore and set it to 0.
  - Counter increments 0..31; after the 32nd step (cycle T+32) go to END.
- END:
  - result_valid=1 from T+33 for a nonzero divisor.
  - Quotient is negated if signed_div and the operand signs differ.
  - Remainder is negated if signed_div and the dividend is negative; the remainder sign always follows the dividend.
  - Results are held stable while in END.
  - result_ack at edge -> IDLE, result_valid=0 next cycle. Results stay readable and are not cleared.
- Overflow case: signed 0x80000000 / 0xFFFFFFFF gives result_lo=0x80000000, result_hi=0 (wraps, no trap).
- annul:
  - In any state, annul=1 at edge -> IDLE next cycle with result_valid=0 and no result update.
  - annul has priority over start and result_ack.
- Simultaneous result_ack & start in END: return to IDLE; the new start is sampled in IDLE on the following edge, which gives back-to-back divides a one-cycle IDLE gap.
- start dropping while ON, without annul: the computation continues to END and waits for result_ack.
- stall_req:
  - Is 1 from the cycle start rises until the cycle result_valid is 1.
  - Is 0 in the ack cycle.
  - Never depends on busy alone.

Test Plan:
- Unsigned 7/2: start with signed_div=0 at T -> stall_req=1 from T through T+32; result_valid=1 at T+33 with result_lo=3, result_hi=1. Ack returns busy=0 next cycle.
- Signed -7/2: dividend=0xFFFFFFF9, divisor=2 -> result_lo=0xFFFFFFFD, result_hi=0xFFFFFFFF. Same operands unsigned -> result_lo=0x7FFFFFFC, result_hi=1.
- Boundary: 0x80000000 / 0xFFFFFFFF signed -> lo=0x80000000, hi=0. Unsigned -> lo=0, hi=0x80000000.
- Divide by zero: dividend=0x1234, divisor=0 -> result_valid at T+2, lo=0xFFFFFFFF, hi=0x1234.
- annul at T+10 -> IDLE at T+11 and result_valid never asserts. A new start 100/7 at T+12 yields lo=14, hi=2 at T+45.
- resetn=0 at T+5 mid-divide -> all outputs 0 and IDLE next cycle. Back-to-back divides, each acked in its END cycle, produce two correct results with a single-cycle IDLE gap between them.
